// File: rtl/pid_sumador_multicanal_pkg.sv
// Shared constants and helpers for the multichannel PID error summer.
// Default width, channel count and counter width live here for all loops.
package pid_sumador_multicanal_pkg;

    localparam int unsigned N_DEF = 16;
    localparam int unsigned C_DEF = 4;
    localparam int unsigned CNT_W = 8;

    function automatic int unsigned ch_width(input int unsigned c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

    // Saturation event counter sticks at all-ones until reset.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pid_sumador_multicanal_saturador.sv
// Combinational clamp of a W+2-bit signed value into [SAT_MIN, SAT_MAX].
// Reusable by other loops; flags report which limit was applied.
module pid_saturador #(
    parameter int unsigned W       = 16,
    parameter longint      SAT_MAX = (longint'(1) << (W - 1)) - 1,
    parameter longint      SAT_MIN = -(longint'(1) << (W - 1))
) (
    input  logic signed [W+1:0] din,
    output logic signed [W-1:0] dout,
    output logic                hi,
    output logic                lo
);

    localparam logic signed [W+1:0] MAX_X = (W + 2)'(SAT_MAX);
    localparam logic signed [W+1:0] MIN_X = (W + 2)'(SAT_MIN);

    always_comb begin
        hi   = (din > MAX_X);
        lo   = (din < MIN_X);
        dout = din[W-1:0];
        if (hi) begin
            dout = MAX_X[W-1:0];
        end else if (lo) begin
            dout = MIN_X[W-1:0];
        end
    end

endmodule

// File: rtl/pid_sumador_multicanal.sv
// Two-stage, saturating ik - pk - dk summer shared by C time-multiplexed
// control channels, with per-channel hold-last-output registers.
module pid_sumador_multicanal
    import pid_sumador_multicanal_pkg::*;
#(
    parameter int unsigned  W       = N_DEF,
    parameter int unsigned  C       = C_DEF,
    parameter longint       SAT_MAX = (longint'(1) << (W - 1)) - 1,
    parameter longint       SAT_MIN = -(longint'(1) << (W - 1)),
    localparam int unsigned CW      = ch_width(C)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                in_valid,
    input  logic [CW-1:0]       in_ch,
    input  logic signed [W-1:0] ik,
    input  logic signed [W-1:0] pk,
    input  logic signed [W-1:0] dk,
    input  logic                clr_ch_valid,
    input  logic [CW-1:0]       clr_ch,
    input  logic [CW-1:0]       rd_ch,
    output logic signed [W-1:0] rd_data,
    output logic                out_valid,
    output logic [CW-1:0]       out_ch,
    output logic signed [W-1:0] resultado,
    output logic                sat_hi,
    output logic                sat_lo,
    output logic [CNT_W-1:0]    sat_cnt
);

    logic                accept;
    logic signed [W+1:0] ik_x, pk_x, dk_x, diff;

    logic                s1_valid;
    logic [CW-1:0]       s1_ch;
    logic signed [W+1:0] s1_val;

    logic signed [W-1:0] sat_val;
    logic                sat_hi_c, sat_lo_c;

    logic signed [W-1:0] ch_regs [C];

    // Two guard bits make the three-operand difference exact.
    assign ik_x   = {{2{ik[W-1]}}, ik};
    assign pk_x   = {{2{pk[W-1]}}, pk};
    assign dk_x   = {{2{dk[W-1]}}, dk};
    assign diff   = ik_x - pk_x - dk_x;
    assign accept = in_valid && enable && (32'(in_ch) < C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_val   <= '0;
        end else begin
            s1_valid <= accept;
            s1_ch    <= in_ch;
            s1_val   <= diff;
        end
    end

    pid_saturador #(
        .W       (W),
        .SAT_MAX (SAT_MAX),
        .SAT_MIN (SAT_MIN)
    ) u_saturador (
        .din  (s1_val),
        .dout (sat_val),
        .hi   (sat_hi_c),
        .lo   (sat_lo_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            resultado <= '0;
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
            sat_cnt   <= '0;
        end else begin
            out_valid <= s1_valid;
            sat_hi    <= s1_valid && sat_hi_c;
            sat_lo    <= s1_valid && sat_lo_c;
            if (s1_valid) begin
                out_ch    <= s1_ch;
                resultado <= sat_val;
                if (sat_hi_c || sat_lo_c) begin
                    sat_cnt <= cnt_sat_inc(sat_cnt);
                end
            end
        end
    end

    // Clear is assigned after the write so it wins on a same-channel collision;
    // out-of-range clear channels match no index and are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < C; i++) begin
                ch_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < C; i++) begin
                if (s1_valid && (s1_ch == CW'(i))) begin
                    ch_regs[i] <= sat_val;
                end
                if (clr_ch_valid && (clr_ch == CW'(i))) begin
                    ch_regs[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < C; i++) begin
            if (rd_ch == CW'(i)) begin
                rd_data = ch_regs[i];
            end
        end
    end

endmodule

// File: tb/tb_pid_sumador_multicanal.sv
// Scoreboard bench: two instances (full-range C=4, and +/-1000 C=3) share stimulus.
module tb_pid_sumador_multicanal;

    typedef struct {
        int ch;
        int res;
        bit hi;
        bit lo;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic enable, in_valid, clr_ch_valid;
    logic [1:0] in_ch, clr_ch, rd_ch;
    logic signed [15:0] ik, pk, dk;

    logic signed [15:0] rdd [2];
    logic signed [15:0] res [2];
    logic ov [2];
    logic hi [2];
    logic lo [2];
    logic [1:0] och [2];
    logic [7:0] cnt [2];

    exp_t q0[$];
    exp_t q1[$];
    int   cntm [2];
    int   mreg [2][4];
    int   nch  [2] = '{4, 3};
    int   mx   [2] = '{32767, 1000};
    int   mn   [2] = '{-32768, -1000};
    bit   pend_cv;
    int   pend_cc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pid_sumador_multicanal #(
        .W (16),
        .C (4)
    ) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_ch(in_ch), .ik(ik), .pk(pk), .dk(dk),
        .clr_ch_valid(clr_ch_valid), .clr_ch(clr_ch), .rd_ch(rd_ch),
        .rd_data(rdd[0]), .out_valid(ov[0]), .out_ch(och[0]),
        .resultado(res[0]), .sat_hi(hi[0]), .sat_lo(lo[0]), .sat_cnt(cnt[0])
    );

    pid_sumador_multicanal #(
        .W       (16),
        .C       (3),
        .SAT_MAX (1000),
        .SAT_MIN (-1000)
    ) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_ch(in_ch), .ik(ik), .pk(pk), .dk(dk),
        .clr_ch_valid(clr_ch_valid), .clr_ch(clr_ch), .rd_ch(rd_ch),
        .rd_data(rdd[1]), .out_valid(ov[1]), .out_ch(och[1]),
        .resultado(res[1]), .sat_hi(hi[1]), .sat_lo(lo[1]), .sat_cnt(cnt[1])
    );

    task automatic check(input string nm, input int d, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d required %0d (t=%0t)", nm, d, act, req, $time);
        end
    endtask

    // Reference: exact integer difference, clamped; counter sticks at 255.
    task automatic push(input int d, input int ch, input int s);
        exp_t e;
        e.ch  = ch;
        e.hi  = (s > mx[d]);
        e.lo  = (s < mn[d]);
        e.res = e.hi ? mx[d] : (e.lo ? mn[d] : s);
        if ((e.hi || e.lo) && cntm[d] < 255) cntm[d]++;
        e.cnt = cntm[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input bit v, input bit en, input int ch, input int i, input int p,
                         input int dv, input bit cv, input int cc, input int rc);
        @(posedge clk);
        #1;
        in_valid     = v;
        enable       = en;
        in_ch        = 2'(ch);
        ik           = 16'(i);
        pk           = 16'(p);
        dk           = 16'(dv);
        clr_ch_valid = cv;
        clr_ch       = 2'(cc);
        rd_ch        = 2'(rc);
        if (v && en) begin
            for (int d = 0; d < 2; d++) begin
                if (ch < nch[d]) push(d, ch, i - p - dv);
            end
        end
    endtask

    task automatic idle(input int n, input int rc);
        for (int k = 0; k < n; k++) drive(0, 1, 0, 0, 0, 0, 0, 0, rc);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        in_valid     = 1'b0;
        clr_ch_valid = 1'b0;
        q0.delete();
        q1.delete();
        cntm[0] = 0;
        cntm[1] = 0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic int rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    function automatic int rndval();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 4000)) - 2000;
        return rnd16();
    endfunction

    task automatic mon_out(input int d);
        exp_t e;
        bit   have;
        if (!ov[d]) return;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out_valid dut%0d: got out_valid=1 ch=%0d required no output (t=%0t)",
                     d, och[d], $time);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check("out_ch", d, int'(och[d]), e.ch);
        check("resultado", d, int'(res[d]), e.res);
        check("sat_hi", d, int'(hi[d]), int'(e.hi));
        check("sat_lo", d, int'(lo[d]), int'(e.lo));
        check("sat_cnt", d, int'(cnt[d]), e.cnt);
        mreg[d][e.ch] = e.res;
    endtask

    // Monitor: outputs reflect the preceding rising edge; the clear seen half a
    // cycle earlier was captured by that same edge and overrides the write.
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                check("reset_out_valid", d, int'(ov[d]), 0);
                check("reset_resultado", d, int'(res[d]), 0);
                check("reset_out_ch", d, int'(och[d]), 0);
                check("reset_sat_flags", d, int'(hi[d]) + int'(lo[d]), 0);
                check("reset_sat_cnt", d, int'(cnt[d]), 0);
                check("reset_rd_data", d, int'(rdd[d]), 0);
                for (int c = 0; c < 4; c++) mreg[d][c] = 0;
            end
            pend_cv = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                mon_out(d);
                if (pend_cv && pend_cc < nch[d]) mreg[d][pend_cc] = 0;
                if (int'(rd_ch) < nch[d]) check("rd_data", d, int'(rdd[d]), mreg[d][rd_ch]);
            end
            pend_cv = clr_ch_valid;
            pend_cc = int'(clr_ch);
        end
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        in_valid     = 1'b0;
        in_ch        = '0;
        ik           = '0;
        pk           = '0;
        dk           = '0;
        clr_ch_valid = 1'b0;
        clr_ch       = '0;
        rd_ch        = '0;
        pend_cv      = 1'b0;
        pend_cc      = 0;
        cntm[0]      = 0;
        cntm[1]      = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic sample on channel 2
        drive(1, 1, 2, 1000, 300, 200, 0, 0, 2);
        idle(3, 2);

        // Saturation high, low, and a value only the narrow instance clamps
        drive(1, 1, 0, 32767, -32768, -32768, 0, 0, 0);
        drive(1, 1, 1, -32768, 32767, 32767, 0, 0, 1);
        drive(1, 1, 2, 1500, 0, 0, 0, 0, 2);
        idle(3, 2);

        // Gating: last accepted sample emerges, then nothing while enable=0
        drive(1, 1, 1, 42, 2, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) drive(1, 0, k % 4, rnd16(), rnd16(), rnd16(), 0, 0, k % 4);
        idle(3, 1);

        // Back-to-back across channels, then same channel twice
        drive(1, 1, 0, 100, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 200, 0, 0, 0, 0, 1);
        drive(1, 1, 2, 300, 0, 0, 0, 0, 2);
        drive(1, 1, 3, 400, 0, 0, 0, 0, 3);
        drive(1, 1, 1, 10, 0, 0, 0, 0, 1);
        drive(1, 1, 1, 20, 0, 0, 0, 0, 1);
        idle(3, 1);

        // Clear collides with the stage-2 write to channel 1
        drive(1, 1, 1, 77, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 1, 1, 1);
        idle(2, 1);

        // Channel 3 is out of range for the C=3 instance (sample and clear)
        drive(1, 1, 3, 555, 0, 0, 0, 0, 3);
        drive(0, 1, 0, 0, 0, 0, 1, 3, 3);
        idle(3, 3);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, int'($urandom_range(0, 3)),
                  rndval(), rndval(), rndval(), $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        idle(3, 0);

        // Reset between acceptance and output
        drive(1, 1, 0, 1234, 0, 0, 0, 0, 0);
        do_reset(2);
        idle(4, 0);

        // Counter saturation at 255
        for (int k = 0; k < 300; k++) drive(1, 1, k % 3, 32767, -32768, -32768, 0, 0, k % 3);
        idle(4, 0);

        for (int d = 0; d < 2; d++) check("sat_cnt_final", d, int'(cnt[d]), 255);
        check("queue_drained", 0, q0.size(), 0);
        check("queue_drained", 1, q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
